xoodyak_io_sequencer: RTL and testbench
=======================================

Name: xoodyak_io_sequencer

Overview:
Word-serial front/back end for the Xoodyak core (xoodyaktop). It collects key, nonce, associated data and text as 32-bit words and holds them stable on the core inputs. It then issues a one-cycle core start and captures the core's text/tag results on encdone. Finally it streams the 10 result words out over a valid/ready interface. It sits directly upstream of the core (feeding its operands) and directly downstream of it (consuming textout/authdata).

Parameters:
TIMEOUT_CYCLES, 64, max cycles in WAIT after core_start before declaring error; must be >= 2.
CNT_W, 7, width of the timeout counter; must hold TIMEOUT_CYCLES.

Ports:
eph1  input  1  clock
reset  input  1  synchronous, active-low reset (0 = reset)
in_valid  input  1  input word valid
in_ready  output  1  sequencer accepts word this cycle
in_data  input  32  operand word
in_opmode  input  1  0 encrypt, 1 decrypt; sampled with word 0
out_valid  output  1  result word valid
out_ready  input  1  downstream accepts result word
out_data  output  32  result word
out_last  output  1  high with final (10th) result word
busy  output  1  high in any state other than LOAD with word count 0
err_timeout  output  1  sticky; set on WAIT timeout, cleared by reset or next word-0 accept
core_start  output  1  one-cycle start pulse to core
core_key  output  128  to core key
core_nonce  output  128  to core nonce
core_assodata  output  128  to core assodata
core_textin  output  192  to core textin
core_opmode  output  1  to core opmode
core_textout  input  192  from core textout
core_authdata  input  128  from core authdata
core_encdone  input  1  from core encdone, one-cycle pulse

Behaviour:
- Reset (reset==0 at posedge eph1) forces the following, regardless of current state:
  - state=LOAD, word count 0, out counter 0.
  - in_ready=0, out_valid=0, out_last=0, core_start=0, busy=0, err_timeout=0.
  - out_data=0; all core_* operand registers 0.
- Load order: the input stream is 18 words, MSB-first per field:
  - words 0-3: key[127:96], key[95:64], key[63:32], key[31:0]
  - words 4-7: nonce, same order
  - words 8-11: assodata, same order
  - words 12-17: textin[191:160] .. textin[31:0]
- Word accept: a word is accepted when in_valid & in_ready at posedge eph1. core_opmode latches in_opmode on the word-0 accept.
- States:
  - LOAD: in_ready=1.
    - Each accept writes the word slot and increments the count.
    - Accepting word 17 -> START and clears the count.
  - START: in_ready=0.
    - core_start=1 for exactly this one cycle.
    - Timeout counter loads 0; next -> WAIT.
  - WAIT: core operands held stable.
    - On core_encdone: capture core_textout and core_authdata into the result register; -> DRAIN.
    - Otherwise the counter increments. When counter == TIMEOUT_CYCLES-1 without encdone: set err_timeout; -> LOAD with no result output.
    - An encdone in the same cycle as the timeout wins (capture, no error).
  - DRAIN: out_valid=1, emitting 10 words in order: textout[191:160] .. textout[31:0], then authdata[127:96] .. authdata[31:0].
    - out_data and out_last are stable while out_valid & !out_ready.
    - Each handshake advances the word.
    - out_last=1 on word 9; its handshake -> LOAD with out_valid=0 on the next cycle.
- Out-of-state handshakes: in_ready=0 in START/WAIT/DRAIN, so in_valid is ignored there. core_encdone outside WAIT is ignored.
- Latency: the last input accept is followed 1 cycle later by core_start. encdone is followed 1 cycle later by out_valid=1.
- Back-to-back: the first word of the next message may be accepted in the cycle after the out_last handshake.
- Operand registers keep their last values in LOAD until overwritten; they change only on accepts.

Decomposition:
- Package xoodyak_pkg holds:
  - state enum (LOAD, START, WAIT, DRAIN)
  - constants IN_WORDS=18, OUT_WORDS=10, WORD_W=32
  - field word-offset constants KEY_OFS=0, NONCE_OFS=4, AD_OFS=8, TEXT_OFS=12
- One sub-module, xoodyak_word_unpacker: 320-bit result register plus 4-bit output index, producing out_data and out_last.

Test Plan:
- Key 000102..0F, nonce 101112..1F, AD 202122..2F, text 303132..47, opmode 0; core model fires encdone 40 cycles after core_start with textout=A5 repeated, authdata=5A repeated:
  - core_start pulses exactly 1 cycle after word 17.
  - The 10 output words are 0xA5A5A5A5 x6 then 0x5A5A5A5A x4; out_last only on word 10.
- Backpressure: out_ready toggled 1,0,0,1 in DRAIN -> out_data/out_last held during stalls; no word skipped or duplicated.
- Timeout: model never raises encdone, TIMEOUT_CYCLES=64 -> err_timeout=1 exactly 64 cycles after core_start; state LOAD; out_valid never asserted; the next word-0 accept clears err_timeout.
- Reset mid-operation: reset=0 for one cycle during WAIT and again during DRAIN word 3 -> all outputs zero next cycle, in_ready=1 in LOAD, a fresh 18-word load completes normally.
- Ignore rules: encdone pulsed during LOAD is ignored; in_valid=1 held during WAIT has no accept and no operand change; encdone coinciding with the timeout cycle -> capture, err_timeout stays 0.
- Back-to-back messages with opmode 1 on the second: core_opmode=1 latched on word 0; the second message's outputs are correct with no idle gap required.

Source files
------------

// File: rtl/xoodyak_pkg.sv
// Shared types and constants for the Xoodyak word-serial I/O sequencer.
package xoodyak_pkg;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam int IN_WORDS  = 18;
  localparam int OUT_WORDS = 10;
  localparam int WORD_W    = 32;

  localparam int KEY_OFS   = 0;
  localparam int NONCE_OFS = 4;
  localparam int AD_OFS    = 8;
  localparam int TEXT_OFS  = 12;

  localparam int WCNT_W    = 5;
  localparam int OIDX_W    = 4;

endpackage

// File: rtl/xoodyak_word_unpacker.sv
// Holds the 320-bit core result and presents it one 32-bit word at a time, MSB word first.
module xoodyak_word_unpacker
  import xoodyak_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        load_i,
  input  logic                        adv_i,
  input  logic                        valid_i,
  input  logic [OUT_WORDS*WORD_W-1:0] data_i,
  output logic [WORD_W-1:0]           out_data_o,
  output logic                        out_last_o
);

  logic [OUT_WORDS*WORD_W-1:0] res_q;
  logic [OIDX_W-1:0]           idx_q;
  logic [WORD_W-1:0]           word_w [OUT_WORDS];

  generate
    for (genvar gi = 0; gi < OUT_WORDS; gi++) begin : g_word
      assign word_w[gi] = res_q[(OUT_WORDS-gi)*WORD_W-1 -: WORD_W];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res_q <= '0;
      idx_q <= '0;
    end else if (load_i) begin
      res_q <= data_i;
      idx_q <= '0;
    end else if (adv_i) begin
      idx_q <= (idx_q == OIDX_W'(OUT_WORDS-1)) ? '0 : idx_q + 1'b1;
    end
  end

  assign out_data_o = word_w[idx_q];
  assign out_last_o = valid_i && (idx_q == OIDX_W'(OUT_WORDS-1));

endmodule

// File: rtl/xoodyak_io_sequencer.sv
// Loads 18 operand words for the Xoodyak core, starts it, waits for encdone
// (with timeout) and streams the 10 result words back out.
module xoodyak_io_sequencer
  import xoodyak_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 7
) (
  input  logic         eph1,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  in_data,
  input  logic         in_opmode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [31:0]  out_data,
  output logic         out_last,
  output logic         busy,
  output logic         err_timeout,
  output logic         core_start,
  output logic [127:0] core_key,
  output logic [127:0] core_nonce,
  output logic [127:0] core_assodata,
  output logic [191:0] core_textin,
  output logic         core_opmode,
  input  logic [191:0] core_textout,
  input  logic [127:0] core_authdata,
  input  logic         core_encdone
);

  state_t                          state_q;
  logic [WCNT_W-1:0]               wcnt_q;
  logic [CNT_W-1:0]                tcnt_q;
  logic [IN_WORDS-1:0][WORD_W-1:0] slot_q;
  logic                            opmode_q;
  logic                            in_ready_q;
  logic                            out_valid_q;
  logic                            core_start_q;
  logic                            err_q;

  logic accept_d;
  logic capture_d;
  logic adv_d;
  logic out_last_w;

  assign accept_d  = in_valid && in_ready_q && (state_q == LOAD);
  assign capture_d = (state_q == WAIT) && core_encdone;
  assign adv_d     = (state_q == DRAIN) && out_valid_q && out_ready;

  // Operand fields are views onto the word slots, first-loaded word in the MSBs.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_quad
      assign core_key[127-32*gi -: 32]      = slot_q[KEY_OFS+gi];
      assign core_nonce[127-32*gi -: 32]    = slot_q[NONCE_OFS+gi];
      assign core_assodata[127-32*gi -: 32] = slot_q[AD_OFS+gi];
    end
    for (genvar gi = 0; gi < 6; gi++) begin : g_text
      assign core_textin[191-32*gi -: 32]   = slot_q[TEXT_OFS+gi];
    end
  endgenerate

  always_ff @(posedge eph1) begin
    if (!reset) begin
      state_q      <= LOAD;
      wcnt_q       <= '0;
      tcnt_q       <= '0;
      slot_q       <= '0;
      opmode_q     <= 1'b0;
      in_ready_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      core_start_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      core_start_q <= 1'b0;
      unique case (state_q)
        LOAD: begin
          in_ready_q <= 1'b1;
          if (accept_d) begin
            slot_q[wcnt_q] <= in_data;
            if (wcnt_q == '0) begin
              opmode_q <= in_opmode;
              err_q    <= 1'b0;
            end
            if (wcnt_q == WCNT_W'(IN_WORDS-1)) begin
              wcnt_q       <= '0;
              state_q      <= START;
              in_ready_q   <= 1'b0;
              core_start_q <= 1'b1;
              tcnt_q       <= '0;
            end else begin
              wcnt_q <= wcnt_q + 1'b1;
            end
          end
        end
        // The timeout counter measures cycles since core_start, so START counts as cycle 0.
        START: begin
          tcnt_q  <= tcnt_q + 1'b1;
          state_q <= WAIT;
        end
        WAIT: begin
          if (core_encdone) begin
            state_q     <= DRAIN;
            out_valid_q <= 1'b1;
          end else if (tcnt_q == CNT_W'(TIMEOUT_CYCLES-1)) begin
            err_q      <= 1'b1;
            state_q    <= LOAD;
            in_ready_q <= 1'b1;
          end else begin
            tcnt_q <= tcnt_q + 1'b1;
          end
        end
        DRAIN: begin
          if (out_ready && out_last_w) begin
            out_valid_q <= 1'b0;
            state_q     <= LOAD;
            in_ready_q  <= 1'b1;
          end
        end
        default: state_q <= LOAD;
      endcase
    end
  end

  xoodyak_word_unpacker u_unpack (
    .clk        (eph1),
    .rst_n      (reset),
    .load_i     (capture_d),
    .adv_i      (adv_d),
    .valid_i    (out_valid_q),
    .data_i     ({core_textout, core_authdata}),
    .out_data_o (out_data),
    .out_last_o (out_last_w)
  );

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_last    = out_last_w;
  assign core_start  = core_start_q;
  assign core_opmode = opmode_q;
  assign err_timeout = err_q;
  assign busy        = (state_q != LOAD) || (wcnt_q != '0);

endmodule

// File: tb/tb_xoodyak_io_sequencer.sv
// Directed scoreboard bench for xoodyak_io_sequencer with a scripted core model.
module tb_xoodyak_io_sequencer;

  logic         eph1 = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_data;
  logic         in_opmode;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  out_data;
  logic         out_last;
  logic         busy;
  logic         err_timeout;
  logic         core_start;
  logic [127:0] core_key;
  logic [127:0] core_nonce;
  logic [127:0] core_assodata;
  logic [191:0] core_textin;
  logic         core_opmode;
  logic [191:0] core_textout;
  logic [127:0] core_authdata;
  logic         core_encdone;

  int n_chk  = 0;
  int n_pass = 0;
  logic [31:0] exp_q[$];

  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] N1 = 128'h101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] A1 = 128'h202122232425262728292a2b2c2d2e2f;
  localparam logic [191:0] T1 = 192'h303132333435363738393a3b3c3d3e3f4041424344454647;
  localparam logic [127:0] K2 = 128'hf0e1d2c3b4a5968778695a4b3c2d1e0f;
  localparam logic [127:0] N2 = 128'h0badcafe_deadbeef_01234567_89abcdef;
  localparam logic [127:0] A2 = 128'h55aa55aa_aa55aa55_12121212_34343434;
  localparam logic [191:0] T2 = 192'hfedcba98_76543210_13579bdf_2468ace0_c001d00d_feedface;
  localparam logic [191:0] TA5 = {6{32'ha5a5a5a5}};
  localparam logic [127:0] A5A = {4{32'h5a5a5a5a}};
  localparam logic [191:0] TSEQ = 192'h11111111_22222222_33333333_44444444_55555555_66666666;
  localparam logic [127:0] ASEQ = 128'h77777777_88888888_99999999_aaaaaaaa;

  xoodyak_io_sequencer #(.TIMEOUT_CYCLES(64), .CNT_W(7)) dut (
    .eph1          (eph1),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .in_opmode     (in_opmode),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_last      (out_last),
    .busy          (busy),
    .err_timeout   (err_timeout),
    .core_start    (core_start),
    .core_key      (core_key),
    .core_nonce    (core_nonce),
    .core_assodata (core_assodata),
    .core_textin   (core_textin),
    .core_opmode   (core_opmode),
    .core_textout  (core_textout),
    .core_authdata (core_authdata),
    .core_encdone  (core_encdone)
  );

  always #5 eph1 = ~eph1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_zero();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_core_start", core_start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err_timeout, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_key", core_key, 0);
    chk("rst_nonce", core_nonce, 0);
    chk("rst_ad", core_assodata, 0);
    chk("rst_textin", core_textin, 0);
    chk("rst_opmode", core_opmode, 0);
  endtask

  // One-cycle reset pulse starting at the current negedge.
  task automatic do_reset();
    reset = 1'b0;
    @(negedge eph1);
    reset = 1'b1;
    chk_zero();
    @(negedge eph1);
    chk("post_rst_in_ready", in_ready, 1);
  endtask

  task automatic send_msg(input logic [127:0] key, input logic [127:0] nonce,
                          input logic [127:0] ad, input logic [191:0] text, input logic op);
    logic [31:0] w [18];
    int guard;
    for (int i = 0; i < 4; i++) begin
      w[i]   = key[127-32*i -: 32];
      w[4+i] = nonce[127-32*i -: 32];
      w[8+i] = ad[127-32*i -: 32];
    end
    for (int i = 0; i < 6; i++) w[12+i] = text[191-32*i -: 32];
    for (int i = 0; i < 18; i++) begin
      in_valid  = 1'b1;
      in_data   = w[i];
      in_opmode = op;
      guard = 0;
      while (!in_ready && guard < 100) begin
        @(negedge eph1);
        guard++;
      end
      if (guard >= 100) chk("in_ready_timeout", in_ready, 1);
      @(negedge eph1);
    end
    in_valid = 1'b0;
    in_data  = 32'h0;
    chk("core_start_after_w17", core_start, 1);
    chk("in_ready_start", in_ready, 0);
    chk("busy_start", busy, 1);
    chk("core_key", core_key, key);
    chk("core_nonce", core_nonce, nonce);
    chk("core_ad", core_assodata, ad);
    chk("core_textin", core_textin, text);
    chk("core_opmode", core_opmode, op);
    chk("err_cleared", err_timeout, 0);
  endtask

  // Core model: raise encdone 'delay' cycles after the current cycle.
  task automatic fire(input int delay, input logic [191:0] tout, input logic [127:0] aut);
    for (int i = 1; i <= delay; i++) begin
      @(negedge eph1);
      if (i == 1) chk("core_start_width", core_start, 0);
    end
    core_textout  = tout;
    core_authdata = aut;
    core_encdone  = 1'b1;
    for (int i = 0; i < 6; i++) exp_q.push_back(tout[191-32*i -: 32]);
    for (int i = 0; i < 4; i++) exp_q.push_back(aut[127-32*i -: 32]);
    @(negedge eph1);
    core_encdone = 1'b0;
    chk("out_valid_after_done", out_valid, 1);
    chk("err_after_done", err_timeout, 0);
  endtask

  task automatic drain(input int nwords, input logic [3:0] pat, input int plen);
    int got = 0;
    int k = 0;
    int guard = 0;
    logic stalled = 1'b0;
    logic [31:0] held_d = '0;
    logic held_l = 1'b0;
    logic [31:0] e;
    while (got < nwords && guard < 200) begin
      out_ready = pat[2'(k % plen)];
      k++;
      if (stalled) begin
        chk("hold_data", out_data, held_d);
        chk("hold_last", out_last, held_l);
      end
      stalled = 1'b0;
      if (out_valid) begin
        if (out_ready) begin
          e = exp_q.pop_front();
          chk("out_data", out_data, e);
          chk("out_last", out_last, exp_q.size() == 0);
          $display("out word %0d: %h last=%0b", got, out_data, out_last);
          got++;
        end else begin
          stalled = 1'b1;
          held_d  = out_data;
          held_l  = out_last;
        end
      end
      @(negedge eph1);
      guard++;
    end
    out_ready = 1'b0;
    if (guard >= 200) chk("drain_timeout", got, nwords);
  endtask

  initial begin
    int ov_seen;
    reset = 1'b0; in_valid = 1'b0; in_data = '0; in_opmode = 1'b0; out_ready = 1'b0;
    core_textout = '0; core_authdata = '0; core_encdone = 1'b0;
    repeat (2) @(negedge eph1);
    do_reset();
    chk("idle_busy", busy, 0);

    // encdone outside WAIT is ignored
    core_encdone = 1'b1;
    @(negedge eph1);
    core_encdone = 1'b0;
    chk("ld_encdone_ov", out_valid, 0);
    chk("ld_encdone_busy", busy, 0);
    @(negedge eph1);
    chk("ld_encdone_ov2", out_valid, 0);

    // Basic message
    send_msg(K1, N1, A1, T1, 1'b0);
    fire(40, TA5, A5A);
    drain(10, 4'b0001, 1);
    chk("drain_end_ov", out_valid, 0);
    chk("drain_end_ready", in_ready, 1);

    // Backpressure 1,0,0,1
    send_msg(K1, N1, A1, T1, 1'b0);
    fire(40, TSEQ, ASEQ);
    drain(10, 4'b1001, 4);
    chk("bp_end_ov", out_valid, 0);

    // Timeout
    send_msg(K2, N2, A2, T2, 1'b0);
    ov_seen = 0;
    for (int k = 1; k <= 64; k++) begin
      @(negedge eph1);
      if (out_valid) ov_seen++;
      if (k == 63) chk("tmo_err_early", err_timeout, 0);
      if (k == 64) begin
        chk("tmo_err_set", err_timeout, 1);
        chk("tmo_in_ready", in_ready, 1);
        chk("tmo_busy", busy, 0);
      end
    end
    chk("tmo_no_out_valid", ov_seen, 0);

    // Reset during WAIT (send_msg also checks that word 0 cleared err_timeout)
    send_msg(K1, N1, A1, T1, 1'b1);
    repeat (10) @(negedge eph1);
    do_reset();

    // Reset during DRAIN word 3, then a fresh message
    send_msg(K1, N1, A1, T1, 1'b0);
    fire(40, TSEQ, ASEQ);
    drain(3, 4'b0001, 1);
    chk("mid_drain_ov", out_valid, 1);
    do_reset();
    exp_q.delete();
    send_msg(K2, N2, A2, T2, 1'b0);
    fire(40, TSEQ, ASEQ);
    drain(10, 4'b0001, 1);

    // in_valid held in WAIT, then encdone on the timeout cycle
    send_msg(K1, N1, A1, T1, 1'b0);
    in_valid = 1'b1;
    in_data  = 32'hdeadbeef;
    repeat (5) @(negedge eph1);
    chk("wait_in_ready", in_ready, 0);
    chk("wait_key_hold", core_key, K1);
    chk("wait_text_hold", core_textin, T1);
    in_valid = 1'b0;
    in_data  = '0;
    fire(58, TA5, ASEQ);
    drain(10, 4'b0001, 1);
    chk("coincide_err", err_timeout, 0);

    // Back-to-back, second with opmode 1
    send_msg(K1, N1, A1, T1, 1'b0);
    fire(10, TSEQ, A5A);
    drain(10, 4'b0001, 1);
    chk("b2b_ready", in_ready, 1);
    send_msg(K2, N2, A2, T2, 1'b1);
    fire(20, TA5, ASEQ);
    drain(10, 4'b0101, 4);
    chk("b2b_end_ov", out_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
